// File: rtl/rvfpm_commit_scheduler.sv
// rvfpm_commit_scheduler
//   Tracks the XIF lifecycle of every instruction ID (FREE -> ISSUED ->
//   COMMITTED/KILLED -> FREE). It also orders FPU results through an
//   in-order FIFO so that a result is released on the XIF result port
//   only once its ID has been committed. Killed results are dropped
//   silently.
// Ports
//   ck, rst                      clock, synchronous active-high reset
//   issue_valid/ready/accept/id  observed XIF issue handshake
//   issue_id_busy                issue_id entry is not FREE (combinational)
//   commit_valid/kill/id         XIF commit
//   fpu_res_*                    result stream from the FPU datapath
//   result_*                     XIF result interface
//   outstanding_cnt              registered count of non-FREE entries
//   protocol_err                 sticky protocol violation flag
module rvfpm_commit_scheduler #(
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RES_DEPTH  = 4
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_ready,
  input  logic                  issue_accept,
  input  logic [X_ID_WIDTH-1:0] issue_id,
  output logic                  issue_id_busy,
  input  logic                  commit_valid,
  input  logic                  commit_kill,
  input  logic [X_ID_WIDTH-1:0] commit_id,
  input  logic                  fpu_res_valid,
  output logic                  fpu_res_ready,
  input  logic [X_ID_WIDTH-1:0] fpu_res_id,
  input  logic [XLEN-1:0]       fpu_res_data,
  input  logic [4:0]            fpu_res_rd,
  input  logic                  fpu_res_we,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [X_ID_WIDTH-1:0] result_id,
  output logic [XLEN-1:0]       result_data,
  output logic [4:0]            result_rd,
  output logic                  result_we,
  output logic [X_ID_WIDTH:0]   outstanding_cnt,
  output logic                  protocol_err
);

  localparam int unsigned NUM_IDS = 2 ** X_ID_WIDTH;
  localparam int unsigned AW      = $clog2(RES_DEPTH);
  localparam int unsigned PW      = AW + 1;

  typedef enum logic [1:0] {
    ST_FREE,
    ST_ISSUED,
    ST_COMMITTED,
    ST_KILLED
  } id_state_e;

  id_state_e state_q [NUM_IDS];
  id_state_e state_d [NUM_IDS];

  logic [X_ID_WIDTH-1:0] fid_q   [RES_DEPTH];
  logic [XLEN-1:0]       fdata_q [RES_DEPTH];
  logic [4:0]            frd_q   [RES_DEPTH];
  logic                  fwe_q   [RES_DEPTH];

  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [X_ID_WIDTH:0]   cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic                  empty, full;
  logic [X_ID_WIDTH-1:0] head_id;
  id_state_e             head_st;
  logic                  issue_fire, fpu_fire, push, pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_id = fid_q[rptr_q[AW-1:0]];
  assign head_st = state_q[head_id];

  assign issue_fire    = issue_valid & issue_ready & issue_accept;
  assign fpu_fire      = fpu_res_valid & ~full;
  assign push          = fpu_fire & (state_q[fpu_res_id] != ST_FREE);
  assign issue_id_busy = (state_q[issue_id] != ST_FREE);
  assign fpu_res_ready = ~full;

  // The head state only leaves COMMITTED through the pop, so the result
  // port holds steady until the handshake.
  assign result_valid = ~empty & (head_st == ST_COMMITTED);
  assign result_id    = result_valid ? head_id : '0;
  assign result_data  = result_valid ? fdata_q[rptr_q[AW-1:0]] : '0;
  assign result_rd    = result_valid ? frd_q[rptr_q[AW-1:0]] : '0;
  assign result_we    = result_valid ? fwe_q[rptr_q[AW-1:0]] : 1'b0;

  assign outstanding_cnt = cnt_q;
  assign protocol_err    = err_q;

  // A head whose ID is already FREE (duplicate FPU result) is discarded
  // so that it cannot block the queue.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      unique case (head_st)
        ST_COMMITTED: pop = result_ready;
        ST_KILLED:    pop = 1'b1;
        ST_FREE:      pop = 1'b1;
        default:      pop = 1'b0;
      endcase
    end
  end

  // Each transition requires a distinct pre-edge state (issue: FREE,
  // commit: ISSUED, pop release: COMMITTED/KILLED), so updates on the same
  // ID cannot collide and updates on distinct IDs all land.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (issue_fire) begin
      if (state_q[issue_id] == ST_FREE) state_d[issue_id] = ST_ISSUED;
      else                              err_d = 1'b1;
    end
    if (commit_valid) begin
      if (state_q[commit_id] == ST_ISSUED)
        state_d[commit_id] = commit_kill ? ST_KILLED : ST_COMMITTED;
      else
        err_d = 1'b1;
    end
    if (fpu_fire && (state_q[fpu_res_id] == ST_FREE)) err_d = 1'b1;
    if (pop && (head_st != ST_FREE)) state_d[head_id] = ST_FREE;

    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;

    cnt_d = '0;
    for (int unsigned i = 0; i < NUM_IDS; i++) begin
      if (state_d[i] != ST_FREE) cnt_d = cnt_d + {{X_ID_WIDTH{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_IDS; i++) state_q[i] <= ST_FREE;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge ck) begin
    if (push) begin
      fid_q[wptr_q[AW-1:0]]   <= fpu_res_id;
      fdata_q[wptr_q[AW-1:0]] <= fpu_res_data;
      frd_q[wptr_q[AW-1:0]]   <= fpu_res_rd;
      fwe_q[wptr_q[AW-1:0]]   <= fpu_res_we;
    end
  end

endmodule

// File: tb/tb_rvfpm_commit_scheduler.sv
// Testbench for rvfpm_commit_scheduler: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_rvfpm_commit_scheduler;

  localparam int IW  = 4;
  localparam int XL  = 32;
  localparam int RD  = 4;
  localparam int NID = 16;

  logic          ck = 1'b0;
  logic          rst;
  logic          issue_valid, issue_ready, issue_accept;
  logic [IW-1:0] issue_id;
  logic          issue_id_busy;
  logic          commit_valid, commit_kill;
  logic [IW-1:0] commit_id;
  logic          fpu_res_valid, fpu_res_ready;
  logic [IW-1:0] fpu_res_id;
  logic [XL-1:0] fpu_res_data;
  logic [4:0]    fpu_res_rd;
  logic          fpu_res_we;
  logic          result_valid, result_ready;
  logic [IW-1:0] result_id;
  logic [XL-1:0] result_data;
  logic [4:0]    result_rd;
  logic          result_we;
  logic [IW:0]   outstanding_cnt;
  logic          protocol_err;

  always #5 ck = ~ck;

  rvfpm_commit_scheduler #(
    .X_ID_WIDTH(IW),
    .XLEN      (XL),
    .RES_DEPTH (RD)
  ) dut (
    .ck             (ck),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_accept   (issue_accept),
    .issue_id       (issue_id),
    .issue_id_busy  (issue_id_busy),
    .commit_valid   (commit_valid),
    .commit_kill    (commit_kill),
    .commit_id      (commit_id),
    .fpu_res_valid  (fpu_res_valid),
    .fpu_res_ready  (fpu_res_ready),
    .fpu_res_id     (fpu_res_id),
    .fpu_res_data   (fpu_res_data),
    .fpu_res_rd     (fpu_res_rd),
    .fpu_res_we     (fpu_res_we),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .result_id      (result_id),
    .result_data    (result_data),
    .result_rd      (result_rd),
    .result_we      (result_we),
    .outstanding_cnt(outstanding_cnt),
    .protocol_err   (protocol_err)
  );

  // Reference model: per-ID lifecycle plus an ordered queue of results.
  typedef enum int {M_FREE, M_ISS, M_COM, M_KIL} st_t;
  typedef struct {
    int          id;
    logic [31:0] data;
    int          rd;
    bit          we;
  } res_t;

  st_t  mst [NID];
  res_t mq[$];
  bit   merr;
  bit   chk_en = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < NID; i++) if (mst[i] != M_FREE) n++;
    return n;
  endfunction

  function automatic bit in_queue(input int id);
    foreach (mq[j]) if (mq[j].id == id) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_update();
    st_t  pre [NID];
    bit   fpu_acc;
    res_t h;
    res_t n;
    if (rst) begin
      for (int i = 0; i < NID; i++) mst[i] = M_FREE;
      mq.delete();
      merr = 1'b0;
      return;
    end
    pre = mst;
    fpu_acc = fpu_res_valid && (mq.size() < RD);
    if (issue_valid && issue_ready && issue_accept) begin
      if (pre[issue_id] == M_FREE) mst[issue_id] = M_ISS;
      else merr = 1'b1;
    end
    if (commit_valid) begin
      if (pre[commit_id] == M_ISS) mst[commit_id] = commit_kill ? M_KIL : M_COM;
      else merr = 1'b1;
    end
    if (mq.size() > 0) begin
      h = mq[0];
      if (pre[h.id] == M_COM && result_ready) begin
        void'(mq.pop_front());
        mst[h.id] = M_FREE;
      end else if (pre[h.id] == M_KIL) begin
        void'(mq.pop_front());
        mst[h.id] = M_FREE;
      end else if (pre[h.id] == M_FREE) begin
        void'(mq.pop_front());
      end
    end
    if (fpu_acc) begin
      if (pre[fpu_res_id] == M_FREE) merr = 1'b1;
      else begin
        n.id = int'(fpu_res_id); n.data = fpu_res_data;
        n.rd = int'(fpu_res_rd); n.we = fpu_res_we;
        mq.push_back(n);
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    bit exp_rv;
    #1;
    if (chk_en) begin
      exp_rv = (mq.size() > 0) && (mst[mq[0].id] == M_COM);
      check("busy", 64'(issue_id_busy), 64'(mst[issue_id] != M_FREE));
      check("fpu_ready", 64'(fpu_res_ready), 64'(mq.size() < RD));
      check("res_valid", 64'(result_valid), 64'(exp_rv));
      if (exp_rv) begin
        check("res_id", 64'(result_id), 64'(mq[0].id));
        check("res_data", 64'(result_data), 64'(mq[0].data));
        check("res_rd", 64'(result_rd), 64'(mq[0].rd));
        check("res_we", 64'(result_we), 64'(mq[0].we));
      end
      check("outstanding", 64'(outstanding_cnt), 64'(model_cnt()));
      check("proto_err", 64'(protocol_err), 64'(merr));
    end
    @(posedge ck);
    model_update();
    @(negedge ck);
  endtask

  task automatic idle();
    rst = 1'b0;
    issue_valid = 1'b0; issue_ready = 1'b0; issue_accept = 1'b0; issue_id = '0;
    commit_valid = 1'b0; commit_kill = 1'b0; commit_id = '0;
    fpu_res_valid = 1'b0; fpu_res_id = '0; fpu_res_data = '0; fpu_res_rd = '0; fpu_res_we = 1'b0;
    result_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; step(); idle();
  endtask

  task automatic do_issue(input int id);
    idle(); issue_valid = 1'b1; issue_ready = 1'b1; issue_accept = 1'b1; issue_id = IW'(id); step();
  endtask

  task automatic do_commit(input int id, input bit kill);
    idle(); commit_valid = 1'b1; commit_kill = kill; commit_id = IW'(id); step();
  endtask

  task automatic do_fpu(input int id, input logic [31:0] data);
    idle(); fpu_res_valid = 1'b1; fpu_res_id = IW'(id); fpu_res_data = data;
    fpu_res_rd = 5'(id + 1); fpu_res_we = 1'b1; step();
  endtask

  function automatic int pick(input st_t s);
    int start = int'($urandom_range(0, NID - 1));
    for (int k = 0; k < NID; k++) if (mst[(start + k) % NID] == s) return (start + k) % NID;
    return -1;
  endfunction

  function automatic int pick_fpu();
    int start = int'($urandom_range(0, NID - 1));
    for (int k = 0; k < NID; k++) begin
      int i = (start + k) % NID;
      if (mst[i] != M_FREE && !in_queue(i)) return i;
    end
    return -1;
  endfunction

  initial begin
    int p;
    idle(); rst = 1'b1;
    @(negedge ck); step();
    chk_en = 1'b1;

    // Reset values
    do_reset();
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_data", 64'(result_data), 64'd0);
    check("rst_ready", 64'(fpu_res_ready), 64'd1);
    check("rst_busy", 64'(issue_id_busy), 64'd0);
    check("rst_cnt", 64'(outstanding_cnt), 64'd0);

    // Single committed result
    do_issue(3); do_commit(3, 1'b0); do_fpu(3, 32'h3F80_0000);
    check("s1_valid", 64'(result_valid), 64'd1);
    check("s1_id", 64'(result_id), 64'd3);
    check("s1_data", 64'(result_data), 64'h3F80_0000);
    idle(); result_ready = 1'b1; step();
    check("s1_cnt", 64'(outstanding_cnt), 64'd0);

    // Out-of-order commits, in-order results
    do_reset();
    do_issue(1); do_issue(2); do_fpu(1, 32'h11); do_fpu(2, 32'h22);
    do_commit(2, 1'b0);
    check("s2_hold0", 64'(result_valid), 64'd0);
    idle(); step();
    check("s2_hold1", 64'(result_valid), 64'd0);
    step();
    check("s2_hold2", 64'(result_valid), 64'd0);
    do_commit(1, 1'b0);
    check("s2_first_valid", 64'(result_valid), 64'd1);
    check("s2_first_id", 64'(result_id), 64'd1);
    idle(); result_ready = 1'b1; step();
    check("s2_second_id", 64'(result_id), 64'd2);
    step();
    check("s2_drained", 64'(result_valid), 64'd0);

    // Killed result is dropped
    do_reset();
    do_issue(5); do_fpu(5, 32'h55); do_commit(5, 1'b1);
    check("s3_valid0", 64'(result_valid), 64'd0);
    idle(); issue_id = IW'(5); step();
    check("s3_valid1", 64'(result_valid), 64'd0);
    check("s3_busy", 64'(issue_id_busy), 64'd0);
    check("s3_cnt", 64'(outstanding_cnt), 64'd0);

    // FIFO full backpressure
    do_reset();
    for (int k = 0; k < 5; k++) do_issue(k);
    for (int k = 0; k < 5; k++) do_commit(k, 1'b0);
    for (int k = 0; k < 4; k++) do_fpu(k, 32'(k * 16));
    check("s4_full", 64'(fpu_res_ready), 64'd0);
    do_fpu(4, 32'h40);
    check("s4_still_full", 64'(fpu_res_ready), 64'd0);
    fpu_res_valid = 1'b1; result_ready = 1'b1; step();
    check("s4_space", 64'(fpu_res_ready), 64'd1);
    result_ready = 1'b0; step();
    idle(); result_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check("s4_cnt", 64'(outstanding_cnt), 64'd0);

    // Protocol errors are sticky
    do_reset();
    do_commit(7, 1'b0);
    check("s5_err_commit", 64'(protocol_err), 64'd1);
    do_issue(3); do_issue(3);
    check("s5_err_issue", 64'(protocol_err), 64'd1);
    check("s5_cnt", 64'(outstanding_cnt), 64'd1);
    idle(); step(); step();
    check("s5_sticky", 64'(protocol_err), 64'd1);
    do_reset();
    check("s5_cleared", 64'(protocol_err), 64'd0);

    // Reset with queued results
    for (int k = 0; k < 3; k++) do_issue(k);
    for (int k = 0; k < 3; k++) do_commit(k, 1'b0);
    for (int k = 0; k < 3; k++) do_fpu(k, 32'hA0 + 32'(k));
    check("s6_pre_valid", 64'(result_valid), 64'd1);
    do_reset();
    check("s6_valid", 64'(result_valid), 64'd0);
    check("s6_cnt", 64'(outstanding_cnt), 64'd0);
    check("s6_ready", 64'(fpu_res_ready), 64'd1);
    check("s6_id", 64'(result_id), 64'd0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      idle();
      rst = ($urandom_range(0, 299) == 0);
      issue_valid  = ($urandom_range(0, 2) == 0);
      issue_ready  = ($urandom_range(0, 3) != 0);
      issue_accept = ($urandom_range(0, 3) != 0);
      p = pick(M_FREE);
      issue_id = (p >= 0 && $urandom_range(0, 9) != 0) ? IW'(p) : IW'($urandom_range(0, NID - 1));
      commit_valid = ($urandom_range(0, 2) == 0);
      commit_kill  = ($urandom_range(0, 3) == 0);
      p = pick(M_ISS);
      commit_id = (p >= 0 && $urandom_range(0, 9) != 0) ? IW'(p) : IW'($urandom_range(0, NID - 1));
      fpu_res_valid = ($urandom_range(0, 1) == 0);
      p = pick_fpu();
      fpu_res_id = (p >= 0 && $urandom_range(0, 9) != 0) ? IW'(p) : IW'($urandom_range(0, NID - 1));
      fpu_res_data = $urandom;
      fpu_res_rd   = 5'($urandom_range(0, 31));
      fpu_res_we   = 1'($urandom_range(0, 1));
      result_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rvfpm_commit_scheduler.md
RVFPM_COMMIT_SCHEDULER -- requirements
Module: rvfpm_commit_scheduler

Interface
REQ-001 Parameter X_ID_WIDTH, default 4, instruction ID width; the ID table holds 2**X_ID_WIDTH entries.
REQ-002 Parameter XLEN, default 32, result data width.
REQ-003 Parameter RES_DEPTH, default 4, result FIFO depth (power of two, >=2).
REQ-004 ck  in  1  clock; the block has one clock and all state updates on the rising edge of ck.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 issue_valid, issue_ready, issue_accept  in  1 each  XIF issue handshake, observed.
REQ-007 issue_id  in  X_ID_WIDTH  ID of the issued instruction.
REQ-008 issue_id_busy  out  1  combinational; high when the entry for issue_id is not FREE; the top level gates issue_ready with it.
REQ-009 commit_valid, commit_kill  in  1 each; commit_id  in  X_ID_WIDTH  XIF commit.
REQ-010 fpu_res_valid  in  1; fpu_res_ready  out  1; fpu_res_id  in  X_ID_WIDTH; fpu_res_data  in  XLEN; fpu_res_rd  in  5; fpu_res_we  in  1  result port from the FPU datapath.
REQ-011 result_valid  out  1; result_ready  in  1; result_id  out  X_ID_WIDTH; result_data  out  XLEN; result_rd  out  5; result_we  out  1  XIF result interface.
REQ-012 outstanding_cnt  out  X_ID_WIDTH+1  number of non-FREE table entries.
REQ-013 protocol_err  out  1  sticky error flag.

Function
REQ-014 Each ID entry holds one of four states: FREE, ISSUED, COMMITTED, KILLED.
REQ-015 An issue fire (issue_valid & issue_ready & issue_accept) to a FREE ID moves it to ISSUED at the next edge.
REQ-016 A commit_valid to an ISSUED ID moves it to COMMITTED if commit_kill=0, and to KILLED if commit_kill=1.
REQ-017 A commit to a FREE, COMMITTED or KILLED ID is ignored and sets protocol_err.
REQ-018 An issue fire to a non-FREE ID leaves the state unchanged and sets protocol_err.
REQ-019 Busy status and every state decision use the pre-edge state; an entry freed in cycle N is reusable by an issue in cycle N+1, not N.
REQ-020 fpu_res_ready = FIFO not full; there is no same-cycle pop bypass.
REQ-021 An FPU fire whose ID is FREE is dropped without enqueue and sets protocol_err; all other FPU fires enqueue {id, data, rd, we}.
REQ-022 The FIFO head is evaluated each cycle against the state of the head ID:
  - COMMITTED: result_valid=1, result_* = head fields.
  - KILLED: head popped silently, entry -> FREE, result_valid=0.
  - ISSUED: head held, result_valid=0.
REQ-023 A result handshake (result_valid & result_ready) pops the head and sets the entry to FREE.
REQ-024 Once asserted, result_valid and result_* stay stable until the handshake.
REQ-025 Latency: an FPU fire in cycle N with an already committed ID gives result_valid in N+1; a commit in cycle N releases a waiting head in N+1.
REQ-026 Results leave strictly in FIFO order; a non-committed head blocks younger results.
REQ-027 Multiple state updates on distinct IDs in one cycle all take effect.
REQ-028 A push and a pop in the same cycle while the FIFO is full is impossible by REQ-020; a push and a pop in the same cycle otherwise keeps the count unchanged.
REQ-029 outstanding_cnt is registered and equals the count of non-FREE entries after each edge.
REQ-030 FIFO pointers are X_ID_WIDTH-independent, log2(RES_DEPTH)+1 bits wide, and wrap modulo 2*RES_DEPTH.

Reset
REQ-031 While rst=1 at an edge: all entries -> FREE, FIFO emptied, protocol_err=0, outstanding_cnt=0.
REQ-032 Outputs after reset: result_valid=0, result_*=0, fpu_res_ready=1, issue_id_busy reflects FREE (0).
REQ-033 A reset asserted mid-operation discards all pending results and states in that same edge; commits and issues sampled in that cycle are ignored.

Verification
REQ-034 Issue ID 3, commit ID 3 (kill=0), FPU result ID 3 data 0x3F800000 -> result_valid next cycle with id=3, data=0x3F800000; after handshake outstanding_cnt=0.
REQ-035 Issue IDs 1,2; FPU results 1 then 2; commit 2 first, then 1 three cycles later -> no result_valid until cycle after commit 1; results then emitted 1 then 2.
REQ-036 Issue ID 5; FPU result ID 5 enqueued; commit ID 5 kill=1 -> head dropped, result_valid never asserted, ID 5 FREE and issue_id_busy=0 two cycles after the commit.
REQ-037 Issue IDs 0-4, hold result_ready=0, commit all, feed 5 FPU results -> fpu_res_ready=0 after 4 enqueued; 5th accepted only after first handshake.
REQ-038 Commit to FREE ID 7, and issue fire to busy ID 3 -> protocol_err=1, sticky until rst; states unchanged.
REQ-039 Assert rst with 3 results queued and result_valid=1 -> next cycle result_valid=0, outstanding_cnt=0, fpu_res_ready=1.
